// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and stream field widths.
// The CHK state exists only when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

    localparam int BYTE_W       = 8;
    localparam int BOOT_LEN_W   = 12;
    localparam int BOOT_LEN_MAX = 4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
`ifdef BOOT_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-receiver and program-memory write bus of the boot loader.
// master = the loader, slave = the byte source / program memory side.
interface boot_loader_if
    import boot_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, prog_we, prog_addr, prog_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, prog_we, prog_addr, prog_wdata
    );
endinterface

// File: rtl/boot_csum.sv
// Modulo-256 byte accumulator for the image checksum (used only with BOOT_CHECKSUM_EN).
// match compares the running sum against the byte currently presented.
module boot_csum
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              clear,
    input  logic              add,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              match
);
    logic [BYTE_W-1:0] sum;

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + byte_in;
        end
    end

    assign match = (sum == byte_in);
endmodule

// File: rtl/boot_loader.sv
// Boot loader: parses LEN_HI, LEN_LO, N x {WORD_HI, WORD_LO} and writes words to program memory from address 0.
// Optional trailing checksum byte enabled by the BOOT_CHECKSUM_EN macro. DATA_W must be 16.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
)(
    input  logic          clk,
    input  logic          arst,
    input  logic          start,
    boot_loader_if.master bus,
    output logic          bootstrapping,
    output logic          done,
    output logic          err
);
    localparam int LEN_HI_W = BOOT_LEN_W - BYTE_W;

    boot_state_t           state;
    logic [LEN_HI_W-1:0]   len_hi;
    logic [BOOT_LEN_W-1:0] word_total;
    logic [BOOT_LEN_W-1:0] word_cnt;
    logic [BYTE_W-1:0]     data_hi;
    logic                  accepting;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  rx_fire;
    logic                  can_start;

    assign rx_fire        = bus.rx_valid && accepting;
    assign can_start      = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign bus.rx_ready   = accepting;
    assign bus.prog_we    = we;
    assign bus.prog_addr  = addr;
    assign bus.prog_wdata = wdata;

`ifdef BOOT_CHECKSUM_EN
    logic csum_add;
    logic csum_match;

    assign csum_add = rx_fire && ((state == ST_DATA_HI) || (state == ST_DATA_LO));

    boot_csum u_csum (
        .clk     (clk),
        .arst    (arst),
        .clear   (start && can_start),
        .add     (csum_add),
        .byte_in (bus.rx_data),
        .match   (csum_match)
    );
`endif

    // NOTE: datapath registers are reset too, so every output is at a known value as soon as arst asserts.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= ST_IDLE;
            len_hi        <= '0;
            word_total    <= '0;
            word_cnt      <= '0;
            data_hi       <= '0;
            accepting     <= 1'b0;
            we            <= 1'b0;
            addr          <= '0;
            wdata         <= '0;
            bootstrapping <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            we <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state         <= ST_LEN_HI;
                        word_cnt      <= '0;
                        addr          <= '0;
                        done          <= 1'b0;
                        err           <= 1'b0;
                        bootstrapping <= 1'b1;
                        accepting     <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_fire) begin
                        if (bus.rx_data[BYTE_W-1:LEN_HI_W] != '0) begin
                            state         <= ST_ERR;
                            err           <= 1'b1;
                            bootstrapping <= 1'b0;
                            accepting     <= 1'b0;
                        end else begin
                            len_hi <= bus.rx_data[LEN_HI_W-1:0];
                            state  <= ST_LEN_LO;
                        end
                    end
                end
                ST_LEN_LO: begin
                    if (rx_fire) begin
                        word_total <= {len_hi, bus.rx_data};
                        if ({len_hi, bus.rx_data} != '0) begin
                            state <= ST_DATA_HI;
                        end else begin
`ifdef BOOT_CHECKSUM_EN
                            state <= ST_CHK;
`else
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            bootstrapping <= 1'b0;
                            accepting     <= 1'b0;
`endif
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (rx_fire) begin
                        data_hi <= bus.rx_data;
                        state   <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (rx_fire) begin
                        we       <= 1'b1;
                        wdata    <= DATA_W'({data_hi, bus.rx_data});
                        addr     <= ADDR_W'(word_cnt);
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt + 1'b1 == word_total) begin
`ifdef BOOT_CHECKSUM_EN
                            state <= ST_CHK;
`else
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            bootstrapping <= 1'b0;
                            accepting     <= 1'b0;
`endif
                        end else begin
                            state <= ST_DATA_HI;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_fire) begin
                        bootstrapping <= 1'b0;
                        accepting     <= 1'b0;
                        if (csum_match) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state         <= ST_IDLE;
                    bootstrapping <= 1'b0;
                    accepting     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random images against a stream-parsing reference model.
// Honours BOOT_CHECKSUM_EN the same way as the RTL.
module tb_boot_loader;
    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic start = 1'b0;
    logic bootstrapping, done, err;

    boot_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    boot_loader #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk           (clk),
        .arst          (arst),
        .start         (start),
        .bus           (bus),
        .bootstrapping (bootstrapping),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] stream_q[$];
    wr_t        exp_q[$];
    wr_t        got_q[$];
    logic       exp_done, exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record every program write, sampled away from the active edge.
    always @(negedge clk) begin
        if (!arst && bus.prog_we) got_q.push_back('{addr: bus.prog_addr, data: bus.prog_wdata});
    end

    // Reference model: parse the byte stream by the format rules.
    task automatic model();
        int         n;
        logic [7:0] sum;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (stream_q[0][7:4] != 4'h0) begin
            exp_err = 1'b1;
            return;
        end
        n   = int'({stream_q[0], stream_q[1]});
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 12'(i), data: {stream_q[2+2*i], stream_q[3+2*i]}});
            sum = 8'(sum + stream_q[2+2*i] + stream_q[3+2*i]);
        end
`ifdef BOOT_CHECKSUM_EN
        if (stream_q[2+2*n] == sum) exp_done = 1'b1;
        else                        exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic append_good_csum();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 2; i < stream_q.size(); i++) s = 8'(s + stream_q[i]);
        stream_q.push_back(s);
`endif
    endtask

    task automatic build_image(input int n, input bit bad_len, input bit bad_csum);
        stream_q.delete();
        if (bad_len) begin
            stream_q.push_back(8'($urandom_range(255, 16)));
            return;
        end
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) stream_q.push_back(8'($urandom));
        append_good_csum();
`ifdef BOOT_CHECKSUM_EN
        if (bad_csum) stream_q[stream_q.size()-1] = 8'(stream_q[stream_q.size()-1] + $urandom_range(255, 1));
`else
        if (bad_csum) stream_q.push_back(8'h00);  // no checksum byte exists; keep image valid
        if (bad_csum) void'(stream_q.pop_back());
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rx_ready) begin
            check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_image(input string name, input int gap_lo, input int gap_hi, input int mid_start_at);
        model();
        got_q.delete();
        pulse_start();
        check({name, "_boot_rise"}, 32'(bootstrapping), 32'd1);
        check({name, "_ready_rise"}, 32'(bus.rx_ready), 32'd1);
        foreach (stream_q[i]) begin
            if (i == mid_start_at) begin
                pulse_start();
                check({name, "_mid_start_boot"}, 32'(bootstrapping), 32'd1);
            end
            send_byte(stream_q[i], int'($urandom_range(gap_hi, gap_lo)));
        end
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_boot_fall"}, 32'(bootstrapping), 32'd0);
        check({name, "_ready_fall"}, 32'(bus.rx_ready), 32'd0);
`ifndef BOOT_CHECKSUM_EN
        if (exp_q.size() > 0 && exp_done) check({name, "_last_we_with_done"}, 32'(bus.prog_we), 32'd1);
`endif
        repeat (3) @(negedge clk);
        check({name, "_done_hold"}, 32'(done), 32'(exp_done));
        check({name, "_we_idle"}, 32'(bus.prog_we), 32'd0);
        check({name, "_n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check({name, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({name, "_prog_we"}, 32'(bus.prog_we), 32'd0);
        check({name, "_prog_addr"}, 32'(bus.prog_addr), 32'd0);
        check({name, "_prog_wdata"}, 32'(bus.prog_wdata), 32'd0);
        check({name, "_boot"}, 32'(bootstrapping), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        arst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle");

        stream_q = {8'h00, 8'h02, 8'h61, 8'hAA, 8'h83, 8'h12};
        append_good_csum();
        run_image("two_words", 0, 0, -1);

        stream_q = {8'h10};
        run_image("len_too_big", 0, 2, -1);

        stream_q = {8'h00, 8'h01, 8'h30, 8'h00};
        append_good_csum();
        run_image("stalled", 5, 5, -1);

`ifdef BOOT_CHECKSUM_EN
        stream_q = {8'h00, 8'h01, 8'h61, 8'hAA, 8'h00};
        run_image("bad_csum", 0, 1, -1);
        stream_q = {8'h00, 8'h01, 8'h61, 8'hAA, 8'h0B};
        run_image("good_csum", 0, 1, -1);
`endif

        // Reset after the first of three words, then a full reload from address 0.
        stream_q = {8'h00, 8'h03, 8'h12, 8'h34};
        got_q.delete();
        pulse_start();
        foreach (stream_q[i]) send_byte(stream_q[i], 0);
        check("pre_reset_boot", 32'(bootstrapping), 32'd1);
        arst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(bus.rx_ready), 32'd0);
        build_image(3, 1'b0, 1'b0);
        run_image("reload", 0, 2, -1);

        // Mid-load start must be ignored; then an empty image completes with no writes.
        build_image(2, 1'b0, 1'b0);
        run_image("mid_start", 0, 1, 3);
        build_image(0, 1'b0, 1'b0);
        run_image("empty", 0, 1, -1);

        for (int k = 0; k < 10; k++) begin
            build_image(int'($urandom_range(6, 0)), ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0));
            run_image("random", 0, 3, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
